// File: rtl/button_cmd_scheduler.sv
// Turns edge-detected operator requests into a single gapped valid/ready command stream.
// Define BUTTON_CMD_SCHEDULER_RR_EN for round-robin arbitration; otherwise lowest pending index wins.
module button_cmd_scheduler #(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 16,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_cmd_ready,
  output logic             o_cmd_valid,
  output logic [ID_W-1:0]  o_cmd_id,
  output logic [N_REQ-1:0] o_pending,
  output logic             o_busy
);

  typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] prev_q;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] rise, clr;
  logic [15:0]      cnt_q, cnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             valid_q, valid_d;
  logic             accept;

`ifdef BUTTON_CMD_SCHEDULER_RR_EN
  logic [ID_W-1:0]  ptr_q, ptr_d;

  // Search starts one past the last accepted channel, wrapping at N_REQ.
  function automatic logic [ID_W-1:0] arb_pick(input logic [N_REQ-1:0] req,
                                               input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    logic            found;
    int              j;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j   = (int'(ptr) + 1 + k) % N_REQ;
      idx = ID_W'(j);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction
`else
  function automatic logic [ID_W-1:0] arb_pick(input logic [N_REQ-1:0] req);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction
`endif

  always_comb begin
    rise   = i_req & ~prev_q;
    accept = valid_q & i_cmd_ready;
    clr    = '0;
    if (accept) clr[id_q] = 1'b1;
    // A rise landing on the accept edge keeps the channel pending.
    pending_d = (pending_q & ~clr) | rise;

    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    valid_d = valid_q;
`ifdef BUTTON_CMD_SCHEDULER_RR_EN
    ptr_d   = ptr_q;
`endif

    case (state_q)
      IDLE: begin
        if (|pending_q) begin
`ifdef BUTTON_CMD_SCHEDULER_RR_EN
          id_d = arb_pick(pending_q, ptr_q);
`else
          id_d = arb_pick(pending_q);
`endif
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (i_cmd_ready) begin
          valid_d = 1'b0;
`ifdef BUTTON_CMD_SCHEDULER_RR_EN
          ptr_d   = id_q;
`endif
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = 16'(GAP_CYCLES - 1);
          end
        end
      end
      GAP: begin
        if (cnt_q == 16'd0) state_d = IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prev_q    <= '1;
      pending_q <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
`ifdef BUTTON_CMD_SCHEDULER_RR_EN
      ptr_q     <= ID_W'(N_REQ - 1);
`endif
    end else begin
      state_q   <= state_d;
      prev_q    <= i_req;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
`ifdef BUTTON_CMD_SCHEDULER_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign o_cmd_valid = valid_q;
  assign o_cmd_id    = id_q;
  assign o_pending   = pending_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// Directed bench for button_cmd_scheduler (N_REQ=4, GAP_CYCLES=4), both arbitration builds.
module tb_button_cmd_scheduler;

`ifdef BUTTON_CMD_SCHEDULER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       rdy;
  logic       o_cmd_valid;
  logic [1:0] o_cmd_id;
  logic [3:0] o_pending;
  logic       o_busy;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  button_cmd_scheduler #(.N_REQ(4), .GAP_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (req),
    .i_cmd_ready(rdy),
    .o_cmd_valid(o_cmd_valid),
    .o_cmd_id   (o_cmd_id),
    .o_pending  (o_pending),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic       v;
    logic       chk_id;
    logic [1:0] id;
    logic [3:0] pend;
    logic       busy;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(input int bound, output int at);
    int i;
    i = 0;
    while (!o_cmd_valid && i < bound) begin
      step();
      i++;
    end
    chk("valid_seen", int'(o_cmd_valid), 1);
    at = cyc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    rdy = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int at, a, prev_v;

    tbl[0]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b0};
    tbl[2]  = '{4'b0010, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1};
    tbl[3]  = '{4'b0010, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1};
    tbl[4]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
    tbl[5]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
    tbl[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
    tbl[7]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
    tbl[8]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0};
    tbl[10] = '{4'b0100, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1};
    tbl[11] = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};

    // Reset with ch1 held high, then hold it for 50 cycles
    rst = 1'b1;
    req = 4'b0010;
    rdy = 1'b0;
    step();
    step();
    chk("reset_valid",   int'(o_cmd_valid), 0);
    chk("reset_id",      int'(o_cmd_id),    0);
    chk("reset_pending", int'(o_pending),   0);
    chk("reset_busy",    int'(o_busy),      0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("held_req_valid", int'(o_cmd_valid), 0);
    end
    chk("held_req_pending", int'(o_pending), 0);

    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req;
      rdy = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_valid", i),   int'(o_cmd_valid), int'(tbl[i].v));
      chk($sformatf("tbl%0d_pending", i), int'(o_pending),   int'(tbl[i].pend));
      chk($sformatf("tbl%0d_busy", i),    int'(o_busy),      int'(tbl[i].busy));
      if (tbl[i].chk_id) chk($sformatf("tbl%0d_id", i), int'(o_cmd_id), int'(tbl[i].id));
    end

    // All four raised together, always ready
    do_reset();
    req = 4'b1111;
    rdy = 1'b1;
    prev_v = 0;
    for (int i = 0; i < 4; i++) begin
      wait_valid(20, at);
      chk("order_id", int'(o_cmd_id), i);
      if (i > 0) chk("order_spacing", at - prev_v, 6);
      prev_v = at;
      step();
    end
    for (int i = 0; i < 6; i++) step();
    chk("order_done_pending", int'(o_pending), 0);
    chk("order_done_busy",    int'(o_busy),    0);

    // Fairness: ch0 re-raised while ch2 is still pending
    do_reset();
    req = 4'b0101;
    wait_valid(10, at);
    chk("fair_first_id", int'(o_cmd_id), 0);
    req = 4'b0100;
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    chk("fair_accept_valid",   int'(o_cmd_valid), 0);
    chk("fair_accept_pending", int'(o_pending),   4'b0100);
    req = 4'b0101;
    step();
    chk("fair_reraise_pending", int'(o_pending), 4'b0101);
    wait_valid(20, at);
    chk("fair_second_id", int'(o_cmd_id), RR ? 2 : 0);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    wait_valid(20, at);
    chk("fair_third_id", int'(o_cmd_id), RR ? 0 : 2);

    // Backpressure on id 3 with a new rise on ch0 meanwhile
    do_reset();
    req = 4'b1000;
    wait_valid(10, at);
    chk("bp_first_id", int'(o_cmd_id), 3);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) req = 4'b1001;
      step();
      chk("bp_valid", int'(o_cmd_valid), 1);
      chk("bp_id",    int'(o_cmd_id),    3);
      chk("bp_busy",  int'(o_busy),      1);
      if (i == 5) chk("bp_pending", int'(o_pending), 4'b1001);
    end
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    chk("bp_accept_valid",   int'(o_cmd_valid), 0);
    chk("bp_accept_pending", int'(o_pending),   4'b0001);
    wait_valid(20, at);
    chk("bp_next_id", int'(o_cmd_id), 0);

    // Rise and accept on ch2 at the same edge
    do_reset();
    req = 4'b0100;
    wait_valid(10, at);
    chk("same_first_id", int'(o_cmd_id), 2);
    req = 4'b0000;
    step();
    chk("same_hold_valid", int'(o_cmd_valid), 1);
    req = 4'b0100;
    rdy = 1'b1;
    step();
    a = cyc;
    rdy = 1'b0;
    chk("same_accept_valid",   int'(o_cmd_valid), 0);
    chk("same_accept_pending", int'(o_pending),   4'b0100);
    wait_valid(20, at);
    chk("same_again_id",      int'(o_cmd_id), 2);
    chk("same_again_spacing", at - a,         5);

    // Reset during OFFER
    do_reset();
    req = 4'b0011;
    wait_valid(10, at);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_offer_valid",   int'(o_cmd_valid), 0);
    chk("rst_offer_pending", int'(o_pending),   0);
    chk("rst_offer_busy",    int'(o_busy),      0);
    for (int i = 0; i < 5; i++) step();
    chk("rst_offer_held_valid",   int'(o_cmd_valid), 0);
    chk("rst_offer_held_pending", int'(o_pending),   0);

    // Reset during GAP with a request pending
    req = 4'b0000;
    step();
    req = 4'b0001;
    wait_valid(10, at);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    chk("gap_busy",  int'(o_busy),      1);
    chk("gap_valid", int'(o_cmd_valid), 0);
    req = 4'b0011;
    step();
    chk("gap_pending", int'(o_pending), 4'b0010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_gap_valid",   int'(o_cmd_valid), 0);
    chk("rst_gap_pending", int'(o_pending),   0);
    chk("rst_gap_busy",    int'(o_busy),      0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
